// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared types and default constants for the UART TX path     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned c_DATA_WIDTH = 8;
  localparam int unsigned c_FIFO_DEPTH = 16;
  localparam int unsigned c_BAUD_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo : single-clock show-ahead FIFO with registered full/empty   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module uart_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_push;
  logic                  w_pop;

  // Both strobes are qualified by the flags as they stood before the edge.
  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop  & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : FIFO-buffered 8N1 serialiser with runtime baud divisor      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [c_BAUD_W-1:0]   baud_div_i,
  input  logic                  tx_we_i,
  input  logic                  tx_en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  tx_bit_o
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] c_BIT_LAST = BW'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  logic [c_BAUD_W-1:0]   r_baud_cnt;
  logic [BW-1:0]         r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;

  logic [c_BAUD_W-1:0]   w_div;
  logic                  w_bit_end;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;

  uart_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (tx_we_i),
    .i_pop   (w_pop),
    .i_din   (din_i),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_div = (baud_div_i == '0) ? c_BAUD_W'(1) : baud_div_i;
  // >= keeps a mid-bit divisor reduction from running the counter through wrap.
  assign w_bit_end = (r_baud_cnt >= (w_div - c_BAUD_W'(1)));

  assign w_pop = tx_en_i & ~w_empty &
                 ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else if (r_state == IDLE) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_tx       <= 1'b1;
      if (w_pop) begin
        r_shift <= w_head;
        r_state <= START;
        r_tx    <= 1'b0;
      end
    end else if (tx_en_i) begin
      if (!w_bit_end) begin
        r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
      end else begin
        r_baud_cnt <= '0;
        case (r_state)
          START: begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
          DATA: begin
            if (r_bit_idx == c_BIT_LAST) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + BW'(1);
              r_tx      <= r_shift[1];
            end
          end
          STOP: begin
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign full_o   = w_full;
  assign empty_o  = w_empty;
  assign tx_bit_o = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx : directed self-checking bench for uart_tx                 |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        tx_we;
  logic        tx_en;
  logic [7:0]  din;
  logic        full;
  logic        empty;
  logic        tx_bit;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_div_i (baud_div),
    .tx_we_i    (tx_we),
    .tx_en_i    (tx_en),
    .din_i      (din),
    .full_o     (full),
    .empty_o    (empty),
    .tx_bit_o   (tx_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    step();
    tx_we = 1'b1;
    din   = v;
    step();
    tx_we = 1'b0;
  endtask

  task automatic idle_bad(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      step();
      if (tx_bit !== 1'b1) bad++;
    end
  endtask

  // Waits for a start bit, then samples every cycle of the frame; f[i] is
  // the level of frame bit i, bad counts cycles that differ from it.
  task automatic rx_frame(input int div, input int pause_at, input int pause_len,
                          output logic [9:0] f, output int waited,
                          output int bad, output logic e0);
    logic lvl;
    f = '0;
    bad = 0;
    waited = 0;
    e0 = 1'bx;
    do begin
      step();
      waited++;
    end while (tx_bit !== 1'b0 && waited < 5000);
    if (tx_bit !== 1'b0) begin
      waited = -1;
      return;
    end
    e0 = empty;
    for (int j = 0; j < 10 * div; j++) begin
      if (j > 0) step();
      lvl = tx_bit;
      if (j % div == 0) f[j / div] = lvl;
      else if (lvl !== f[j / div]) bad++;
      if (j == pause_at) begin
        tx_en = 1'b0;
        repeat (pause_len) begin
          step();
          if (tx_bit !== lvl) bad++;
        end
        tx_en = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] f, f2;
    int         w, w2, bad, bad2, acc_w, acc_bad;
    logic       e, e2;

    rst = 1'b1; tx_we = 1'b0; tx_en = 1'b0; baud_div = 16'd16; din = '0;
    #1;
    check("rst_tx", tx_bit, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    #22 rst = 1'b0;

    // Fill the FIFO with 0..15 while disabled.
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      push(8'(k));
      if (tx_bit !== 1'b1) bad++;
      if (k == 0)  check("empty_after_first", empty, 1'b0);
      if (k == 14) check("full_after_15", full, 1'b0);
      if (k == 15) check("full_after_16", full, 1'b1);
    end
    push(8'hFF);
    check("full_after_drop", full, 1'b1);
    check("tx_idle_while_filling", bad, 0);

    step();
    tx_en = 1'b1;
    acc_w = 0; acc_bad = 0;
    for (int i = 0; i < 16; i++) begin
      rx_frame(16, -1, 0, f, w, bad, e);
      check($sformatf("fifo_frame_%0d", i), {22'd0, f}, {22'd0, 1'b1, 8'(i), 1'b0});
      if (w != 1) acc_w++;
      acc_bad += bad;
    end
    check("fifo_frames_back_to_back", acc_w, 0);
    check("fifo_frames_bit_hold", acc_bad, 0);
    check("fifo_drained_empty", empty, 1'b1);
    idle_bad(200, bad);
    check("no_dropped_byte_sent", bad, 0);
    tx_en = 1'b0;

    // Single 0xA5 frame at divisor 16.
    push(8'hA5);
    check("a5_empty_after_push", empty, 1'b0);
    step();
    tx_en = 1'b1;
    rx_frame(16, -1, 0, f, w, bad, e);
    check("a5_start_latency", w, 1);
    check("a5_empty_at_start", e, 1'b1);
    check("a5_frame", {22'd0, f}, {22'd0, 10'b1_1010_0101_0});
    check("a5_bit_hold", bad, 0);
    idle_bad(40, bad);
    check("a5_idle_after", bad, 0);
    tx_en = 1'b0;

    // Two queued bytes at divisor 4 leave no gap between frames.
    baud_div = 16'd4;
    push(8'h55);
    push(8'h0F);
    step();
    tx_en = 1'b1;
    rx_frame(4, -1, 0, f, w, bad, e);
    rx_frame(4, -1, 0, f2, w2, bad2, e2);
    check("b2b_frame1", {22'd0, f}, {22'd0, 10'b1_0101_0101_0});
    check("b2b_frame2", {22'd0, f2}, {22'd0, 10'b1_0000_1111_0});
    check("b2b_first_latency", w, 1);
    check("b2b_no_gap", w2, 1);
    check("b2b_empty_first_pop", e, 1'b0);
    check("b2b_empty_second_pop", e2, 1'b1);
    check("b2b_bit_hold", bad + bad2, 0);
    idle_bad(20, bad);
    check("b2b_idle_after", bad, 0);
    tx_en = 1'b0;

    // Pause for 50 cycles in the middle of data bit 3 (frame bit 4).
    baud_div = 16'd8;
    push(8'hC3);
    step();
    tx_en = 1'b1;
    rx_frame(8, 4 * 8 + 3, 50, f, w, bad, e);
    check("pause_frame", {22'd0, f}, {22'd0, 10'b1_1100_0011_0});
    check("pause_bit_hold", bad, 0);
    idle_bad(20, bad);
    check("pause_idle_after", bad, 0);
    tx_en = 1'b0;

    // Asynchronous reset mid-frame with divisor 0 behaving as 1.
    baud_div = 16'd0;
    push(8'h00);
    push(8'h00);
    step();
    tx_en = 1'b1;
    step(); step(); step();
    check("pre_rst_tx_low", tx_bit, 1'b0);
    check("pre_rst_not_empty", empty, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_tx", tx_bit, 1'b1);
    check("async_rst_empty", empty, 1'b1);
    #2 rst = 1'b0;
    idle_bad(50, bad);
    check("post_rst_no_frame", bad, 0);
    check("post_rst_empty", empty, 1'b1);
    push(8'h5A);
    rx_frame(1, -1, 0, f, w, bad, e);
    check("post_rst_frame", {22'd0, f}, {22'd0, 10'b1_0101_1010_0});
    check("post_rst_latency", w, 1);
    check("post_rst_bit_hold", bad, 0);
    tx_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
